tl_state_timer: RTL

- Downstream stage of the traffic-light next-state logic: holds the current state `cs` and commits the proposed next state `ns` only after the state's dwell time has elapsed.
- Drives the decoded light outputs for street A (`La`) and street B (`Lb`).
- Feeds `cs` back to the next-state logic.
- Adds a minimum-green time, a fixed yellow duration, and a sticky illegal-transition flag.

---
 rtl/tl_pkg.sv | 27 ++
 rtl/tl_out_logic.sv | 26 ++
 rtl/tl_state_timer.sv | 95 +++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller.
//   tl_state_e  : current/next state encoding (S0..S3)
//   tl_light_e  : light code driven onto each street
//   state_limit : dwell length (cycles) required in a given state
package tl_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,   // A green,  B red
        S1 = 2'b01,   // A yellow, B red
        S2 = 2'b10,   // B green,  A red
        S3 = 2'b11    // B yellow, A red
    } tl_state_e;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } tl_light_e;

    // Green states use the minimum-green time, yellow states the fixed yellow time.
    function automatic int state_limit(input tl_state_e st,
                                       input int        green_cycles,
                                       input int        yellow_cycles);
        return ((st == S0) || (st == S2)) ? green_cycles : yellow_cycles;
    endfunction

endpackage

// File: rtl/tl_out_logic.sv
// Light decoder: maps the current state onto the light codes of both streets.
// Purely combinational so it can also be dropped into the structural controller.
//   cs : current state (in)
//   La : light code for street A (out)
//   Lb : light code for street B (out)
module tl_out_logic
    import tl_pkg::*;
(
    input  logic [1:0] cs,
    output logic [1:0] La,
    output logic [1:0] Lb
);

    always_comb begin
        La = RED;
        Lb = RED;
        case (tl_state_e'(cs))
            S0: begin La = GREEN;  Lb = RED;    end
            S1: begin La = YELLOW; Lb = RED;    end
            S2: begin La = RED;    Lb = GREEN;  end
            S3: begin La = RED;    Lb = YELLOW; end
            default: begin La = RED; Lb = RED; end
        endcase
    end

endmodule

// File: rtl/tl_state_timer.sv
// State register with dwell timer for the traffic-light controller.
// Holds the current state and only commits the proposed next state once the
// state's dwell time is met; flags illegal proposals seen while it would accept.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   ns           : proposed next state from the next-state logic
//   cs           : registered current state (fed back to the next-state logic)
//   La, Lb       : decoded light codes for streets A and B
//   dwell_done   : dwell requirement of the current state is met
//   state_change : one-cycle pulse in the cycle after cs changes
//   illegal      : sticky, illegal ns seen while dwell_done was high
//
// state | meaning
// ------+---------------------
// S0    | A green,  B red
// S1    | A yellow, B red
// S2    | B green,  A red
// S3    | B yellow, A red
module tl_state_timer
    import tl_pkg::*;
#(
    parameter int GREEN_MIN_CYCLES = 10,
    parameter int YELLOW_CYCLES    = 5,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] ns,
    output logic [1:0] cs,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       dwell_done,
    output logic       state_change,
    output logic       illegal
);

    tl_state_e        cs_q, cs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sc_q, sc_d;
    logic             ill_q, ill_d;

    logic [CNT_W-1:0] limit_m1;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       adv_state;
    logic             ns_is_adv;
    logic             ns_is_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q  <= S0;
            cnt_q <= '0;
            sc_q  <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            cs_q  <= cs_d;
            cnt_q <= cnt_d;
            sc_q  <= sc_d;
            ill_q <= ill_d;
        end
    end

    always_comb begin
        limit_m1      = CNT_W'(state_limit(cs_q, GREEN_MIN_CYCLES, YELLOW_CYCLES) - 1);
        dwell_done    = (cnt_q >= limit_m1);
        adv_state     = cs_q + 2'd1;
        ns_is_adv     = (ns == adv_state);
        ns_is_illegal = (ns != cs_q) && !ns_is_adv;
        // Saturate so a long green never wraps and drops dwell_done.
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        cs_d  = cs_q;
        cnt_d = cnt_inc;
        sc_d  = 1'b0;
        ill_d = ill_q;

        if (dwell_done && ns_is_adv) begin
            cs_d  = tl_state_e'(ns);
            cnt_d = '0;
            sc_d  = 1'b1;
        end else if (dwell_done && ns_is_illegal) begin
            ill_d = 1'b1;
        end
    end

    assign cs           = cs_q;
    assign state_change = sc_q;
    assign illegal      = ill_q;

    tl_out_logic u_out_logic (
        .cs (cs_q),
        .La (La),
        .Lb (Lb)
    );

endmodule
